// File: rtl/piece_move_ctrl.sv
// Active-piece sequencer: owns the four cell coordinates and the 4x4 anchor,
// and serialises rotate/shift/drop/gravity moves with a one-cycle lock pulse.
module piece_move_ctrl #(
   parameter int GRAV_PERIOD = 25000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [20:1][10:1] grid,
   input  logic              spawn_req,
   input  logic [15:0]       spawn_x,
   input  logic [19:0]       spawn_y,
   input  logic [3:0]        spawn_ax,
   input  logic [4:0]        spawn_ay,
   input  logic              req_rot,
   input  logic              req_left,
   input  logic              req_right,
   input  logic              req_down,
   input  logic              req_hard,
   input  logic              rot_en,
   input  logic [3:0]        rot_x1,
   input  logic [3:0]        rot_x2,
   input  logic [3:0]        rot_x3,
   input  logic [3:0]        rot_x4,
   input  logic [4:0]        rot_y1,
   input  logic [4:0]        rot_y2,
   input  logic [4:0]        rot_y3,
   input  logic [4:0]        rot_y4,
   output logic [3:0]        xpos1,
   output logic [3:0]        xpos2,
   output logic [3:0]        xpos3,
   output logic [3:0]        xpos4,
   output logic [4:0]        ypos1,
   output logic [4:0]        ypos2,
   output logic [4:0]        ypos3,
   output logic [4:0]        ypos4,
   output logic [3:0]        shapexLoc,
   output logic [4:0]        shapeyLoc,
   output logic              piece_valid,
   output logic              setShape,
   output logic              game_over
);

   localparam int CW = $clog2(GRAV_PERIOD);
   localparam logic [CW-1:0] GRAV_LAST = CW'(GRAV_PERIOD - 1);

   typedef enum logic [1:0] {EMPTY, ACTIVE, EVAL, LOCK} state_t;
   typedef enum logic [1:0] {OP_ROT, OP_LEFT, OP_RIGHT, OP_DOWN} op_t;

   state_t        state;
   op_t           op;
   logic [3:0]    cx [4];
   logic [4:0]    cy [4];
   logic [3:0]    ax;
   logic [4:0]    ay;
   logic [3:0]    pend;          // {rot, left, right, down}
   logic          hard;
   logic [CW-1:0] gcnt;

   logic [3:0]    nx [4];
   logic [4:0]    ny [4];
   logic [3:0]    nax;
   logic [4:0]    nay;
   logic [3:0]    sx [4];
   logic [4:0]    sy [4];
   logic [3:0]    rx [4];
   logic [4:0]    ry [4];
   logic [3:0]    self_hit;
   logic [3:0]    cell_ok;
   logic [3:0]    spawn_occ;
   logic          shift_ok;
   logic          move_ok;
   logic          spawn_hit;
   logic          live;
   logic          down_ok;
   logic          grav_tick;
   logic [3:0]    pend_set;
   logic [3:0]    pend_clr;
   logic [3:0]    pend_nxt;

   function automatic logic in_range(input logic [3:0] x, input logic [4:0] y);
      return (x >= 4'd1) && (x <= 4'd10) && (y >= 5'd1) && (y <= 5'd20);
   endfunction

   assign rx[0] = rot_x1;
   assign rx[1] = rot_x2;
   assign rx[2] = rot_x3;
   assign rx[3] = rot_x4;
   assign ry[0] = rot_y1;
   assign ry[1] = rot_y2;
   assign ry[2] = rot_y3;
   assign ry[3] = rot_y4;

   always_comb begin
      nax = ax;
      nay = ay;
      for (int unsigned i = 0; i < 4; i++) begin
         sx[i] = spawn_x[4*i +: 4];
         sy[i] = spawn_y[5*i +: 5];
         nx[i] = cx[i];
         ny[i] = cy[i];
         case (op)
            OP_ROT: begin
               nx[i] = rx[i];
               ny[i] = ry[i];
            end
            OP_LEFT:  nx[i] = cx[i] - 4'd1;
            OP_RIGHT: nx[i] = cx[i] + 4'd1;
            OP_DOWN:  ny[i] = cy[i] + 5'd1;
            default: ;
         endcase
      end
      case (op)
         OP_LEFT:  nax = ax - 4'd1;
         OP_RIGHT: nax = ax + 4'd1;
         OP_DOWN:  nay = ay + 5'd1;
         default: ;
      endcase
   end

   // A candidate cell may land on a grid bit only if the piece itself sits there.
   always_comb begin
      self_hit  = '0;
      cell_ok   = '0;
      spawn_occ = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         for (int unsigned j = 0; j < 4; j++) begin
            if (nx[i] == cx[j] && ny[i] == cy[j])
               self_hit[i] = 1'b1;
         end
         if (in_range(nx[i], ny[i]))
            cell_ok[i] = !grid[ny[i]][nx[i]] || self_hit[i];
         if (in_range(sx[i], sy[i]))
            spawn_occ[i] = grid[sy[i]][sx[i]];
      end
   end

   assign shift_ok  = &cell_ok;
   assign move_ok   = (op == OP_ROT) ? rot_en : shift_ok;
   assign spawn_hit = |spawn_occ;
   assign live      = (state == ACTIVE) || (state == EVAL);
   assign down_ok   = (state == EVAL) && (op == OP_DOWN) && shift_ok;
   // A legal down restarts the gravity period, so a coincident wrap is dropped.
   assign grav_tick = live && (gcnt == GRAV_LAST) && !down_ok;

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (live)
         pend_set = {req_rot, req_left, req_right,
                     req_down | req_hard | grav_tick | ((state == ACTIVE) && hard)};
      if (state == EVAL)
         pend_clr = 4'b1000 >> op;
      pend_nxt = (pend & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= EMPTY;
         op          <= OP_ROT;
         for (int unsigned i = 0; i < 4; i++) begin
            cx[i] <= '0;
            cy[i] <= '0;
         end
         ax          <= '0;
         ay          <= '0;
         pend        <= '0;
         hard        <= 1'b0;
         gcnt        <= '0;
         piece_valid <= 1'b0;
         setShape    <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (live) begin
            gcnt <= (down_ok || gcnt == GRAV_LAST) ? '0 : gcnt + 1'b1;
            if (req_hard)
               hard <= 1'b1;
         end
         case (state)
            EMPTY: begin
               if (spawn_req && !game_over) begin
                  if (spawn_hit) begin
                     game_over <= 1'b1;
                  end else begin
                     for (int unsigned i = 0; i < 4; i++) begin
                        cx[i] <= sx[i];
                        cy[i] <= sy[i];
                     end
                     ax          <= spawn_ax;
                     ay          <= spawn_ay;
                     piece_valid <= 1'b1;
                     gcnt        <= '0;
                     state       <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (|pend) begin
                  state <= EVAL;
                  if (pend[3])      op <= OP_ROT;
                  else if (pend[2]) op <= OP_LEFT;
                  else if (pend[1]) op <= OP_RIGHT;
                  else              op <= OP_DOWN;
               end
            end
            EVAL: begin
               if (move_ok) begin
                  for (int unsigned i = 0; i < 4; i++) begin
                     cx[i] <= nx[i];
                     cy[i] <= ny[i];
                  end
                  ax    <= nax;
                  ay    <= nay;
                  state <= ACTIVE;
               end else if (op == OP_DOWN) begin
                  setShape <= 1'b1;
                  state    <= LOCK;
               end else begin
                  state <= ACTIVE;
               end
            end
            LOCK: begin
               setShape    <= 1'b0;
               piece_valid <= 1'b0;
               for (int unsigned i = 0; i < 4; i++) begin
                  cx[i] <= '0;
                  cy[i] <= '0;
               end
               ax    <= '0;
               ay    <= '0;
               pend  <= '0;
               hard  <= 1'b0;
               gcnt  <= '0;
               state <= EMPTY;
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign xpos1     = cx[0];
   assign xpos2     = cx[1];
   assign xpos3     = cx[2];
   assign xpos4     = cx[3];
   assign ypos1     = cy[0];
   assign ypos2     = cy[1];
   assign ypos3     = cy[2];
   assign ypos4     = cy[3];
   assign shapexLoc = ax;
   assign shapeyLoc = ay;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Scoreboard bench for piece_move_ctrl: stimulus queues cycle-stamped expected
// output snapshots; a negedge monitor pops and compares them.
module tb_piece_move_ctrl;

   logic              clk = 1'b0;
   logic              reset;
   logic [20:1][10:1] grid;
   logic              spawn_req;
   logic [15:0]       spawn_x;
   logic [19:0]       spawn_y;
   logic [3:0]        spawn_ax;
   logic [4:0]        spawn_ay;
   logic              req_rot, req_left, req_right, req_down, req_hard;
   logic              rot_en;
   logic [3:0]        rot_x1, rot_x2, rot_x3, rot_x4;
   logic [4:0]        rot_y1, rot_y2, rot_y3, rot_y4;
   logic [3:0]        xpos1, xpos2, xpos3, xpos4;
   logic [4:0]        ypos1, ypos2, ypos3, ypos4;
   logic [3:0]        shapexLoc;
   logic [4:0]        shapeyLoc;
   logic              piece_valid, setShape, game_over;

   piece_move_ctrl #(.GRAV_PERIOD(8)) dut (
      .clk(clk), .reset(reset), .grid(grid),
      .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .spawn_ax(spawn_ax), .spawn_ay(spawn_ay),
      .req_rot(req_rot), .req_left(req_left), .req_right(req_right),
      .req_down(req_down), .req_hard(req_hard),
      .rot_en(rot_en),
      .rot_x1(rot_x1), .rot_x2(rot_x2), .rot_x3(rot_x3), .rot_x4(rot_x4),
      .rot_y1(rot_y1), .rot_y2(rot_y2), .rot_y3(rot_y3), .rot_y4(rot_y4),
      .xpos1(xpos1), .xpos2(xpos2), .xpos3(xpos3), .xpos4(xpos4),
      .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3), .ypos4(ypos4),
      .shapexLoc(shapexLoc), .shapeyLoc(shapeyLoc),
      .piece_valid(piece_valid), .setShape(setShape), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // snapshot: {x4..x1, y4..y1, anchor x, anchor y, piece_valid, setShape, game_over}
   logic [47:0] act;
   assign act = {xpos4, xpos3, xpos2, xpos1, ypos4, ypos3, ypos2, ypos1,
                 shapexLoc, shapeyLoc, piece_valid, setShape, game_over};

   localparam logic [47:0] ZERO = '0;
   localparam logic [47:0] GO   = 48'd1;

   int          qc[$];
   string       qn[$];
   logic [47:0] qv[$];
   int          total = 0;
   int          bad = 0;
   bit          finishing = 1'b0;

   function automatic logic [15:0] hx(input logic [3:0] a);
      return {a + 4'd3, a + 4'd2, a + 4'd1, a};
   endfunction

   function automatic logic [19:0] ry(input logic [4:0] y);
      return {y, y, y, y};
   endfunction

   function automatic logic [47:0] mk(input logic [15:0] xs, input logic [19:0] ys,
                                      input logic [3:0] ax, input logic [4:0] ay,
                                      input logic v, input logic s, input logic g);
      return {xs, ys, ax, ay, v, s, g};
   endfunction

   task automatic push(input int c, input string n, input logic [47:0] v);
      qc.push_back(c);
      qn.push_back(n);
      qv.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      push(cyc, "reset", ZERO);
   endtask

   task automatic spawn(input logic [15:0] xs, input logic [19:0] ys,
                        input logic [3:0] ax, input logic [4:0] ay, output int s);
      spawn_x   = xs;
      spawn_y   = ys;
      spawn_ax  = ax;
      spawn_ay  = ay;
      spawn_req = 1'b1;
      step();
      spawn_req = 1'b0;
      s = cyc;
   endtask

   task automatic pulse(input logic r, input logic l, input logic rt,
                        input logic d, input logic h, output int p);
      req_rot   = r;
      req_left  = l;
      req_right = rt;
      req_down  = d;
      req_hard  = h;
      step();
      {req_rot, req_left, req_right, req_down, req_hard} = '0;
      p = cyc;
   endtask

   // monitor: compares every expectation stamped for the current cycle
   initial begin
      forever begin
         @(negedge clk);
         while (qc.size() > 0 && (qc[0] <= cyc || finishing)) begin
            total++;
            if (qc[0] != cyc) begin
               bad++;
               $display("FAIL %s: expectation for cycle %0d not checked on time (now %0d)",
                        qn[0], qc[0], cyc);
            end else if (act !== qv[0]) begin
               bad++;
               $display("FAIL %s @%0d: got %h want %h", qn[0], cyc, act, qv[0]);
            end
            void'(qc.pop_front());
            void'(qn.pop_front());
            void'(qv.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, p;
      logic [47:0] e;
      grid = '0;
      {spawn_req, req_rot, req_left, req_right, req_down, req_hard, rot_en} = '0;
      spawn_x = '0; spawn_y = '0; spawn_ax = '0; spawn_ay = '0;
      rot_x1 = 4'd6; rot_x2 = 4'd6; rot_x3 = 4'd6; rot_x4 = 4'd6;
      rot_y1 = 5'd1; rot_y2 = 5'd2; rot_y3 = 5'd3; rot_y4 = 5'd4;
      reset = 1'b1;
      step();
      do_reset();
      step();

      // spawn then legal left, position updates exactly 2 cycles after pulse
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      push(s, "spawn", e);
      pulse(0, 1, 0, 0, 0, p);
      push(p + 1, "left_wait", e);
      push(p + 2, "left", mk(hx(3), ry(1), 4'd3, 5'd1, 1'b1, 1'b0, 1'b0));
      repeat (3) step();
      do_reset();

      // left wall
      spawn(hx(1), ry(1), 4'd1, 5'd1, s);
      e = mk(hx(1), ry(1), 4'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      pulse(0, 1, 0, 0, 0, p);
      push(p + 2, "left_wall", e);
      push(p + 3, "left_wall_hold", e);
      repeat (3) step();
      do_reset();

      // right wall
      spawn(hx(7), ry(1), 4'd7, 5'd1, s);
      e = mk(hx(7), ry(1), 4'd7, 5'd1, 1'b1, 1'b0, 1'b0);
      pulse(0, 0, 1, 0, 0, p);
      push(p + 2, "right_wall", e);
      push(p + 3, "right_wall_hold", e);
      repeat (3) step();
      do_reset();

      // right onto column 10 is legal
      spawn(hx(6), ry(1), 4'd6, 5'd1, s);
      pulse(0, 0, 1, 0, 0, p);
      push(p + 2, "right_to_edge", mk(hx(7), ry(1), 4'd7, 5'd1, 1'b1, 1'b0, 1'b0));
      repeat (3) step();
      do_reset();

      // right blocked by a committed cell at (8,1)
      grid[1][8] = 1'b1;
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      push(s, "spawn_beside_block", e);
      pulse(0, 0, 1, 0, 0, p);
      push(p + 2, "right_blocked", e);
      repeat (3) step();
      grid = '0;
      do_reset();

      // rot + left + down together: served in priority order at 2-cycle spacing
      rot_en = 1'b1;
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      pulse(1, 1, 0, 1, 0, p);
      push(p + 1, "multi_wait", e);
      e = mk(16'h6666, {5'd4, 5'd3, 5'd2, 5'd1}, 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      push(p + 2, "multi_rot", e);
      push(p + 3, "multi_rot_hold", e);
      push(p + 4, "multi_left",
           mk(16'h5555, {5'd4, 5'd3, 5'd2, 5'd1}, 4'd3, 5'd1, 1'b1, 1'b0, 1'b0));
      push(p + 6, "multi_down",
           mk(16'h5555, {5'd5, 5'd4, 5'd3, 5'd2}, 4'd3, 5'd2, 1'b1, 1'b0, 1'b0));
      repeat (7) step();
      rot_en = 1'b0;
      do_reset();

      // gravity down after 8 cycles of ACTIVE, evaluated two cycles later
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      push(s + 9, "grav_wait", e);
      push(s + 10, "grav_down", mk(hx(4), ry(2), 4'd4, 5'd2, 1'b1, 1'b0, 1'b0));
      repeat (11) step();
      do_reset();

      // O piece on the floor: gravity down illegal -> one-cycle lock pulse
      spawn(16'h6565, {5'd20, 5'd20, 5'd19, 5'd19}, 4'd4, 5'd17, s);
      e = mk(16'h6565, {5'd20, 5'd20, 5'd19, 5'd19}, 4'd4, 5'd17, 1'b1, 1'b0, 1'b0);
      push(s, "o_spawn", e);
      push(s + 9, "lock_wait", e);
      push(s + 10, "lock_pulse",
           mk(16'h6565, {5'd20, 5'd20, 5'd19, 5'd19}, 4'd4, 5'd17, 1'b1, 1'b1, 1'b0));
      push(s + 11, "lock_clear", ZERO);
      push(s + 12, "lock_once", ZERO);
      repeat (12) step();
      do_reset();

      // hard drop from row 17: one row per 3 cycles after the first, then lock
      spawn(hx(4), ry(17), 4'd4, 5'd16, s);
      pulse(0, 0, 0, 0, 1, p);
      push(p + 1, "hard_eval", mk(hx(4), ry(17), 4'd4, 5'd16, 1'b1, 1'b0, 1'b0));
      push(p + 2, "hard_row18", mk(hx(4), ry(18), 4'd4, 5'd17, 1'b1, 1'b0, 1'b0));
      push(p + 5, "hard_row19", mk(hx(4), ry(19), 4'd4, 5'd18, 1'b1, 1'b0, 1'b0));
      e = mk(hx(4), ry(20), 4'd4, 5'd19, 1'b1, 1'b0, 1'b0);
      push(p + 8, "hard_row20", e);
      push(p + 10, "hard_pre_lock", e);
      push(p + 11, "hard_lock", mk(hx(4), ry(20), 4'd4, 5'd19, 1'b1, 1'b1, 1'b0));
      push(p + 12, "hard_clear", ZERO);
      repeat (12) step();
      do_reset();

      // move request together with spawn in EMPTY is dropped
      req_left = 1'b1;
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      req_left = 1'b0;
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      push(s, "spawn_with_move", e);
      push(s + 2, "spawn_move_ignored", e);
      push(s + 3, "spawn_move_ignored2", e);
      repeat (3) step();
      do_reset();

      // reset while a legal left is in EVAL
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      e = mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0);
      pulse(0, 1, 0, 0, 0, p);
      push(p + 1, "pre_reset_eval", e);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      push(p + 2, "reset_mid_eval", ZERO);
      push(p + 3, "reset_mid_eval_after", ZERO);
      step();
      step();

      // spawn collision -> sticky game_over, later spawns ignored until reset
      grid[1][5] = 1'b1;
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      push(s, "game_over", GO);
      step();
      grid = '0;
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      push(s, "spawn_ignored", GO);
      push(s + 2, "spawn_ignored_hold", GO);
      repeat (2) step();
      do_reset();
      spawn(hx(4), ry(1), 4'd4, 5'd1, s);
      push(s, "spawn_after_reset", mk(hx(4), ry(1), 4'd4, 5'd1, 1'b1, 1'b0, 1'b0));

      repeat (3) step();
      finishing = 1'b1;
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/piece_move_ctrl.md
Name: piece_move_ctrl

Overview:
Sequencer for the active falling piece. Owns the four cell coordinates and the 4x4 bounding-box anchor, and arbitrates the move requests: rotate, left, right, soft drop, hard drop and gravity. It evaluates one move at a time. Rotation legality comes from the external rotation checker; shift legality is computed locally against the playfield grid. It issues a one-cycle lock pulse when the piece can no longer fall.

Parameters:
GRAV_PERIOD, 25000000, clk cycles between gravity down-requests (minimum 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
grid  in  20x10  playfield; row r (1..20, 20 = bottom), column c (1..10); 1 = occupied by committed cell
spawn_req  in  1  one-cycle pulse: load new piece
spawn_x  in  16  four 4-bit x coords, cell1 in [3:0]
spawn_y  in  20  four 5-bit y coords, cell1 in [4:0]
spawn_ax  in  4  spawn anchor x
spawn_ay  in  5  spawn anchor y
req_rot, req_left, req_right, req_down, req_hard  in  1 each  one-cycle request pulses
rot_en  in  1  rotation checker: rotation legal
rot_x1..rot_x4  in  4 each  rotation checker candidate x
rot_y1..rot_y4  in  5 each  rotation checker candidate y
xpos1..xpos4  out  4 each  current cell x (also drive the rotation checker)
ypos1..ypos4  out  5 each  current cell y
shapexLoc  out  4  anchor x; 0 when no piece
shapeyLoc  out  5  anchor y; 0 when no piece
piece_valid  out  1  active piece present
setShape  out  1  one-cycle lock pulse; piece cells are to be committed to grid
game_over  out  1  sticky spawn-collision flag

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state EMPTY, pending bits, hard-drop flag and gravity counter cleared. Reset overrides every other event in the same cycle.
- Pending latch, 4 bits {rot, left, right, down}: each sets on its request pulse or on a gravity/hard-drop event. Each clears when its move is evaluated. Set wins over clear in the same cycle. Pulses arriving outside ACTIVE/EVAL are discarded.
- EMPTY:
  - piece_valid = 0; anchor outputs = 0.
  - spawn_req with game_over = 0: load spawn coords and anchor. If any spawn cell is occupied in grid, set game_over, stay EMPTY, keep outputs 0. Otherwise go to ACTIVE with piece_valid = 1, gravity counter = 0.
- ACTIVE:
  - If any pending bit is set, latch the highest-priority one (rot > left > right > down) into op and go to EVAL next cycle. Otherwise stay.
  - req_hard sets the hard flag. While the hard flag is set, the down bit is re-set every ACTIVE cycle.
- EVAL (exactly 1 cycle; 2 cycles minimum from request to updated position):
  - rot: if rot_en = 1, load rot_x*/rot_y*. The anchor is unchanged.
  - left/right: candidate x -/+ 1 for all cells and anchor.
  - down: candidate y + 1 for all cells and anchor.
  - A shift is legal iff every candidate cell has x in 1..10 and y in 1..20, and its grid bit is 0 or the cell equals one of the current four cells. Compares are on the full 4/5-bit values: x = 1 - 1 = 0 is illegal, 10 + 1 = 11 is illegal, y = 21 is illegal.
  - Legal: update positions; clear the op bit; return to ACTIVE.
  - Illegal rot/left/right: clear the op bit, positions unchanged, return to ACTIVE.
  - Illegal down: go to LOCK.
- LOCK: setShape = 1 for exactly one cycle with positions held. Next cycle: EMPTY, piece_valid = 0, positions/anchor zeroed, pending and hard flag cleared.
- Gravity counter:
  - Runs in ACTIVE and EVAL. At GRAV_PERIOD-1 it sets the down bit and wraps to 0.
  - Zeroed on spawn and after every legal down move, so the next gravity step is a full period away.
- A rotation request during hard drop is still served first by priority.
- Simultaneous spawn_req and any move request in EMPTY: the move request is ignored.
- game_over clears only on reset; spawn_req is ignored while it is set.

Test Plan:
- Reset mid-EVAL (legal left pending) -> next cycle all outputs 0, state EMPTY, no position change, setShape = 0.
- Spawn cells (4,1),(5,1),(6,1),(7,1), anchor (4,1), empty grid -> piece_valid = 1 next cycle. Then req_left -> xpos1 = 3 exactly 2 cycles after the pulse; anchor x = 3.
- Piece at x = 1..4: req_left -> positions unchanged, no lock. Piece at x = 7..10: req_right -> unchanged.
- req_rot, req_left, req_down in the same cycle, all legal, rot_en = 1 -> rotation applied first, then left, then down, at 2-cycle spacing. All three pending bits are served.
- GRAV_PERIOD = 8; O piece with cells at rows 19-20 on an empty grid -> down evaluated, illegal. setShape high for exactly one cycle, then piece_valid = 0 and shapexLoc = 0.
- grid[1][5] = 1, spawn covering (5,1) -> game_over = 1, piece_valid = 0. A later spawn_req stays ignored until reset.
